stage_sequencer: RTL and testbench
==================================

# stage_sequencer

Multi-cycle control FSM for the core. It drives one-cycle `enabled` pulses to fetch, decode, execute, memory and writeback in strict order, and waits on each stage's `completed` before advancing. It owns the architectural PC: after writeback it commits `pc+4` or the jump target that execute latched. It also provides halt handling, a per-stage watchdog, and cycle and retired-instruction counters.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded at reset.
- `TIMEOUT`, default 1024: maximum cycles a stage may take, counted after its enable pulse, before an error is raised.
- `CNT_W`, default 32: width of the cycle and retired-instruction counters.
- `clk`  in  1  clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `start`  in  1  leaves IDLE and begins fetching at `pc`.
- `fetch_completed`, `decode_completed`, `exec_completed`, `mem_completed`, `wb_completed`  in  1 each  stage done flags.
- `is_halt`  in  1  decode's halt indication, valid while `decode_completed`=1.
- `is_jump_chosen`  in  1  execute's branch/jump decision, valid while `exec_completed`=1.
- `jump_dest`  in  32  execute's target, valid while `exec_completed`=1.
- `fetch_enabled`, `decode_enabled`, `exec_enabled`, `mem_enabled`, `wb_enabled`  out  1 each  one-cycle start pulses.
- `pc`  out  32  PC of the instruction in flight.
- `busy`  out  1  high in any state other than IDLE, HALTED or ERROR.
- `halted`  out  1  high in HALTED.
- `error`  out  1  high in ERROR.
- `cycle_count`  out  CNT_W  cycles spent with `busy`=1.
- `retired`  out  CNT_W  writebacks completed.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED, ERROR.
- IDLE:
  - `start`=1 moves to FETCH.
  - `start` is ignored in every other state.
- Entering a stage state X:
  - X_enabled is high for exactly the entry cycle.
  - The watchdog counter clears to 0.
- Completion handling in stage state X:
  - X_completed is ignored in the entry cycle, because stages assert completed only while not enabled.
  - From the cycle after entry, X_completed=1 moves to the next state: FETCH→DECODE→EXEC→MEM→WB.
- Decode completion: `is_halt` is latched into `halt_pending`.
- Exec completion:
  - `is_jump_chosen` is latched into `jump_taken`.
  - `jump_dest` is latched into `target`, with bits [1:0] forced to 0.
- WB completion:
  - `retired` increments (wraps modulo 2^CNT_W).
  - `pc` becomes `target` if `jump_taken` is set, else `pc+4` (32-bit wrap: 32'hFFFF_FFFC → 0).
  - If `halt_pending` is set, go to HALTED with `pc` still updated; otherwise go to FETCH.
- Watchdog: if the counter reaches TIMEOUT in any stage state without completion, go to ERROR. `pc` is held at the offending instruction.
- HALTED and ERROR are terminal; only `rstn` exits them.
- Any completed input whose stage is not the current state is ignored.
- `cycle_count` increments every cycle while `busy`=1 and wraps.

## Timing
- Reset values:
  - `pc`=RESET_PC.
  - All `*_enabled`=0, `busy`=0, `halted`=0, `error`=0, `cycle_count`=0, `retired`=0.
  - State IDLE; `halt_pending`, `jump_taken` and `target` cleared.
- Reset mid-operation: at the reset edge everything returns to the reset values above; no enable pulse is emitted in that cycle.
- All outputs are registered.
- Start: `start` sampled high at edge t gives `fetch_enabled`=1 in cycle t+1.
- Stage hand-off: X_completed sampled high at edge t gives the next stage's enable pulse in cycle t+1. This is a 1-cycle hand-off per stage.
- Minimum instruction latency, when every stage completes in the cycle after its enable: 10 cycles from `fetch_enabled` to the next `fetch_enabled`.
- The new `pc` is visible in the same cycle as the next `fetch_enabled`.
- Timeout: with the enable pulse in cycle e and no completion, `error` is high from cycle e+TIMEOUT+1.

## Test plan
- Straight line:
  - Stimulus: reset with RESET_PC=0, `start`, every stage completes 1 cycle after its enable, no jumps, 3 instructions.
  - Response: `pc` goes 0→4→8→12; `retired`=3; fetch pulses 10 cycles apart.
- Taken jump:
  - Stimulus: at exec completion `is_jump_chosen`=1, `jump_dest`=32'h0000_0103.
  - Response: after WB, `pc`=32'h0000_0100.
- Not-taken branch:
  - Stimulus: `is_jump_chosen`=0, `jump_dest`=32'h200.
  - Response: `pc`=`pc+4`.
- Halt:
  - Stimulus: `is_halt`=1 at decode completion.
  - Response: MEM and WB still run, `retired` increments, then `halted`=1 with no further `fetch_enabled`; a later `start` has no effect.
- Watchdog:
  - Stimulus: TIMEOUT=8, hold `mem_completed`=0.
  - Response: `error`=1 exactly 9 cycles after `mem_enabled`, and `busy`=0.
- Robustness:
  - Stimulus: assert `exec_completed` during FETCH, and `decode_completed` in the same cycle as `decode_enabled`.
  - Response: both are ignored; FSM order is unchanged.
  - Stimulus: `rstn`=0 during EXEC.
  - Response: all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/stage_sequencer.sv
// stage_sequencer
//
// Multi-cycle control FSM for the core. Walks one instruction at a time through
// fetch -> decode -> execute -> memory -> writeback. Each stage gets a one-cycle
// enable pulse on entry, and the FSM waits for that stage's completed flag before
// moving on. The block owns the architectural PC. After writeback it commits
// pc+4 or the jump target latched at execute completion.
//
// Parameters
//   RESET_PC  PC value loaded at reset.
//   TIMEOUT   cycles a stage may take after its enable pulse before ERROR.
//   CNT_W     width of the cycle and retired-instruction counters.
//
// Ports
//   clk, rstn                clock; synchronous active-low reset
//   start                    leaves IDLE (ignored in every other state)
//   *_completed              per-stage done flags
//   is_halt                  halt indication, valid with decode_completed
//   is_jump_chosen           jump decision, valid with exec_completed
//   jump_dest                jump target, valid with exec_completed
//   *_enabled                one-cycle stage start pulses
//   pc                       PC of the instruction in flight
//   busy / halted / error    status flags
//   cycle_count              cycles spent busy
//   retired                  writebacks completed
//
// All outputs are registered.

module stage_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 1024,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             fetch_completed,
  input  logic             decode_completed,
  input  logic             exec_completed,
  input  logic             mem_completed,
  input  logic             wb_completed,
  input  logic             is_halt,
  input  logic             is_jump_chosen,
  input  logic [31:0]      jump_dest,
  output logic             fetch_enabled,
  output logic             decode_enabled,
  output logic             exec_enabled,
  output logic             mem_enabled,
  output logic             wb_enabled,
  output logic [31:0]      pc,
  output logic             busy,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalted,
    StError
  } state_e;

  // Bit positions within the enable vector.
  localparam int unsigned IdxFetch  = 0;
  localparam int unsigned IdxDecode = 1;
  localparam int unsigned IdxExec   = 2;
  localparam int unsigned IdxMem    = 3;
  localparam int unsigned IdxWb     = 4;

  // The watchdog must be able to hold the value TIMEOUT itself.
  localparam int unsigned WdW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT);

  state_e           state_q, state_d;
  logic [4:0]       en_q, en_d;
  logic [WdW-1:0]   wd_q, wd_d;
  logic [31:0]      pc_q, pc_d;
  logic             halt_pending_q, halt_pending_d;
  logic             jump_taken_q, jump_taken_d;
  logic [31:0]      target_q, target_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic             busy_q, busy_d;
  logic             halted_q, halted_d;
  logic             error_q, error_d;

  logic entry;
  logic in_stage;
  logic stage_done;

  // An enable bit is high exactly in a stage's entry cycle. Stages never raise
  // completed while enabled, so completion is masked in that cycle.
  assign entry = |en_q;

  always_comb begin : done_mux
    in_stage   = 1'b0;
    stage_done = 1'b0;
    unique case (state_q)
      StFetch: begin
        in_stage   = 1'b1;
        stage_done = fetch_completed;
      end
      StDecode: begin
        in_stage   = 1'b1;
        stage_done = decode_completed;
      end
      StExec: begin
        in_stage   = 1'b1;
        stage_done = exec_completed;
      end
      StMem: begin
        in_stage   = 1'b1;
        stage_done = mem_completed;
      end
      StWb: begin
        in_stage   = 1'b1;
        stage_done = wb_completed;
      end
      default: begin
        in_stage   = 1'b0;
        stage_done = 1'b0;
      end
    endcase
    stage_done = stage_done & ~entry;
  end

  always_comb begin : next_state
    state_d        = state_q;
    en_d           = '0;
    wd_d           = wd_q;
    pc_d           = pc_q;
    halt_pending_d = halt_pending_q;
    jump_taken_d   = jump_taken_q;
    target_d       = target_q;
    retired_d      = retired_q;
    cycle_count_d  = busy_q ? cycle_count_q + CNT_W'(1) : cycle_count_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d        = StFetch;
          en_d[IdxFetch] = 1'b1;
          wd_d           = '0;
        end
      end
      StFetch: begin
        if (stage_done) begin
          state_d         = StDecode;
          en_d[IdxDecode] = 1'b1;
        end
      end
      StDecode: begin
        if (stage_done) begin
          state_d        = StExec;
          en_d[IdxExec]  = 1'b1;
          halt_pending_d = is_halt;
        end
      end
      StExec: begin
        if (stage_done) begin
          state_d      = StMem;
          en_d[IdxMem] = 1'b1;
          jump_taken_d = is_jump_chosen;
          // Instructions are word aligned; drop any low target bits.
          target_d     = jump_dest & 32'hFFFF_FFFC;
        end
      end
      StMem: begin
        if (stage_done) begin
          state_d     = StWb;
          en_d[IdxWb] = 1'b1;
        end
      end
      StWb: begin
        if (stage_done) begin
          retired_d = retired_q + CNT_W'(1);
          pc_d      = jump_taken_q ? target_q : pc_q + 32'd4;
          // The halting instruction still commits its PC before stopping.
          if (halt_pending_q) begin
            state_d = StHalted;
          end else begin
            state_d        = StFetch;
            en_d[IdxFetch] = 1'b1;
          end
        end
      end
      StHalted, StError: begin
        state_d = state_q;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Watchdog shared by all stage states. A completion in the cycle the limit
    // is reached still wins over the timeout.
    if (in_stage) begin
      if (stage_done) begin
        wd_d = '0;
      end else if (wd_q == WdLimit) begin
        state_d = StError;
      end else begin
        wd_d = wd_q + WdW'(1);
      end
    end

    busy_d   = (state_d != StIdle) && (state_d != StHalted) && (state_d != StError);
    halted_d = (state_d == StHalted);
    error_d  = (state_d == StError);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= StIdle;
      en_q           <= '0;
      wd_q           <= '0;
      pc_q           <= RESET_PC;
      halt_pending_q <= 1'b0;
      jump_taken_q   <= 1'b0;
      target_q       <= '0;
      retired_q      <= '0;
      cycle_count_q  <= '0;
      busy_q         <= 1'b0;
      halted_q       <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      en_q           <= en_d;
      wd_q           <= wd_d;
      pc_q           <= pc_d;
      halt_pending_q <= halt_pending_d;
      jump_taken_q   <= jump_taken_d;
      target_q       <= target_d;
      retired_q      <= retired_d;
      cycle_count_q  <= cycle_count_d;
      busy_q         <= busy_d;
      halted_q       <= halted_d;
      error_q        <= error_d;
    end
  end

  assign fetch_enabled  = en_q[IdxFetch];
  assign decode_enabled = en_q[IdxDecode];
  assign exec_enabled   = en_q[IdxExec];
  assign mem_enabled    = en_q[IdxMem];
  assign wb_enabled     = en_q[IdxWb];
  assign pc             = pc_q;
  assign busy           = busy_q;
  assign halted         = halted_q;
  assign error          = error_q;
  assign cycle_count    = cycle_count_q;
  assign retired        = retired_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Testbench for stage_sequencer. Directed and randomized instruction sequences
// are driven from one initial block; expected PC, retired count and busy-cycle
// count come from a simple instruction-level model kept here.

module tb_stage_sequencer;

  localparam int unsigned Timeout = 8;
  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        fetch_completed, decode_completed, exec_completed, mem_completed, wb_completed;
  logic        is_halt, is_jump_chosen;
  logic [31:0] jump_dest;
  logic        fetch_enabled, decode_enabled, exec_enabled, mem_enabled, wb_enabled;
  logic [31:0] pc;
  logic        busy, halted, error;
  logic [31:0] cycle_count, retired;

  stage_sequencer #(
    .RESET_PC(ResetPc),
    .TIMEOUT (Timeout),
    .CNT_W   (32)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .start           (start),
    .fetch_completed (fetch_completed),
    .decode_completed(decode_completed),
    .exec_completed  (exec_completed),
    .mem_completed   (mem_completed),
    .wb_completed    (wb_completed),
    .is_halt         (is_halt),
    .is_jump_chosen  (is_jump_chosen),
    .jump_dest       (jump_dest),
    .fetch_enabled   (fetch_enabled),
    .decode_enabled  (decode_enabled),
    .exec_enabled    (exec_enabled),
    .mem_enabled     (mem_enabled),
    .wb_enabled      (wb_enabled),
    .pc              (pc),
    .busy            (busy),
    .halted          (halted),
    .error           (error),
    .cycle_count     (cycle_count),
    .retired         (retired)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_fetch = -1;

  // Instruction-level model.
  bit          model_busy;
  logic [31:0] pc_m;
  logic [31:0] retired_m;
  logic [31:0] cyc_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] ens();
    return {wb_enabled, mem_enabled, exec_enabled, decode_enabled, fetch_enabled};
  endfunction

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    if (model_busy) cyc_m++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_model();
    pc_m       = ResetPc;
    retired_m  = '0;
    cyc_m      = '0;
    model_busy = 1'b0;
    last_fetch = -1;
  endtask

  // mode 0: quiet, 1: random noise, 2: every other completed flag and start held high.
  task automatic drive(input int own, input bit own_val, input int mode);
    logic [4:0] c;
    c = (mode == 2) ? 5'h1f : (mode == 1) ? 5'($urandom) : 5'h00;
    if (own >= 0) c[own] = own_val;
    {wb_completed, mem_completed, exec_completed, decode_completed, fetch_completed} = c;
    start = (mode == 2) ? 1'b1 : (mode == 1) ? 1'($urandom) : 1'b0;
    if (mode != 0) begin
      is_halt        = 1'($urandom);
      is_jump_chosen = 1'($urandom);
      jump_dest      = $urandom;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"}, 64'(pc), 64'(ResetPc));
    chk({tag, "_en"}, 64'(ens()), 64'(5'h00));
    chk({tag, "_busy"}, 64'(busy), 64'(1'b0));
    chk({tag, "_halted"}, 64'(halted), 64'(1'b0));
    chk({tag, "_error"}, 64'(error), 64'(1'b0));
    chk({tag, "_cycles"}, 64'(cycle_count), 64'(0));
    chk({tag, "_retired"}, 64'(retired), 64'(0));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    drive(-1, 1'b0, 0);
    model_busy = 1'b0;
    step();
    step();
    chk_reset("rst");
    rstn = 1'b1;
    reset_model();
    step();
    chk_reset("rst_idle");
  endtask

  task automatic begin_run();
    start = 1'b1;
    step();
    start = 1'b0;
    model_busy = 1'b1;
  endtask

  // Run one instruction starting in its fetch entry cycle. abort_stage < 5 stops at
  // that stage: abort_kind 0 applies reset one cycle after entry, 1 stalls it.
  task automatic run_instr(input bit halt, input bit jmp, input logic [31:0] dest,
                           input int lat_max, input int mode,
                           input int abort_stage, input int abort_kind);
    int k;
    bit entry_val;
    for (int s = 0; s < 5; s++) begin
      chk($sformatf("en_s%0d", s), 64'(ens()), 64'(5'b00001 << s));
      chk($sformatf("pc_s%0d", s), 64'(pc), 64'(pc_m));
      chk($sformatf("busy_s%0d", s), 64'(busy), 64'(1'b1));
      if (s == 0) begin
        chk("cycle_count", 64'(cycle_count), 64'(cyc_m));
        chk("retired", 64'(retired), 64'(retired_m));
        last_fetch = cyc;
      end
      // Own completed during the entry cycle must be ignored.
      entry_val = (mode == 2) ? 1'b1 : (mode == 1) ? 1'($urandom) : 1'b0;
      drive(s, entry_val, mode);
      if (s == abort_stage) begin
        if (abort_kind == 0) begin
          step();
          drive(s, 1'b0, mode);
          rstn = 1'b0;
          step();
          chk_reset("midrst");
          rstn = 1'b1;
          reset_model();
          drive(-1, 1'b0, 0);
        end else begin
          for (int j = 1; j <= int'(Timeout); j++) begin
            step();
            chk($sformatf("wd_err_%0d", j), 64'(error), 64'(1'b0));
            chk($sformatf("wd_busy_%0d", j), 64'(busy), 64'(1'b1));
            drive(s, 1'b0, mode);
          end
          step();
          model_busy = 1'b0;
          chk("wd_error", 64'(error), 64'(1'b1));
          chk("wd_busy", 64'(busy), 64'(1'b0));
          chk("wd_en", 64'(ens()), 64'(5'h00));
          chk("wd_pc", 64'(pc), 64'(pc_m));
          chk("wd_halted", 64'(halted), 64'(1'b0));
        end
        return;
      end
      k = (lat_max <= 1) ? 1 : int'($urandom_range(lat_max, 1));
      for (int j = 1; j <= k; j++) begin
        step();
        chk($sformatf("wait_en_s%0d", s), 64'(ens()), 64'(5'h00));
        if (j < k) begin
          drive(s, 1'b0, mode);
        end else begin
          drive(s, 1'b1, mode);
          if (s == 1) is_halt = halt;
          if (s == 2) begin
            is_jump_chosen = jmp;
            jump_dest      = dest;
          end
        end
      end
      step();
    end
    retired_m = retired_m + 32'd1;
    pc_m      = jmp ? (dest & 32'hFFFF_FFFC) : pc_m + 32'd4;
    if (halt) model_busy = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    drive(-1, 1'b0, 0);
    is_halt        = 1'b0;
    is_jump_chosen = 1'b0;
    jump_dest      = '0;
    do_reset();

    // Idle: completed noise without start must not wake the FSM.
    repeat (4) begin
      drive(-1, 1'b0, 1);
      start = 1'b0;
      step();
      chk("idle_busy", 64'(busy), 64'(1'b0));
      chk("idle_en", 64'(ens()), 64'(5'h00));
    end

    // Straight line, minimum latency.
    begin_run();
    repeat (3) run_instr(1'b0, 1'b0, 32'h0, 1, 0, 5, 0);
    chk("sl_pc", 64'(pc), 64'(32'd12));
    chk("sl_retired", 64'(retired), 64'(32'd3));
    chk("sl_gap", 64'(cyc - last_fetch), 64'(10));

    // Taken jump with misaligned target, then not-taken branch.
    run_instr(1'b0, 1'b1, 32'h0000_0103, 1, 0, 5, 0);
    chk("jmp_pc", 64'(pc), 64'(32'h0000_0100));
    run_instr(1'b0, 1'b0, 32'h0000_0200, 1, 0, 5, 0);
    chk("nt_pc", 64'(pc), 64'(32'h0000_0104));

    // PC wrap at the top of the address space.
    run_instr(1'b0, 1'b1, 32'hFFFF_FFFE, 1, 0, 5, 0);
    chk("top_pc", 64'(pc), 64'(32'hFFFF_FFFC));
    run_instr(1'b0, 1'b0, 32'h0, 1, 0, 5, 0);
    chk("wrap_pc", 64'(pc), 64'(32'h0));

    // Out-of-state completions and same-cycle-as-enable completions held high.
    repeat (2) run_instr(1'b0, 1'($urandom), $urandom, 3, 2, 5, 0);

    // Randomized latencies, jumps and input noise.
    repeat (25) run_instr(1'b0, 1'($urandom), $urandom, 6, 1, 5, 0);

    // Halt: the halting instruction completes MEM/WB and retires.
    run_instr(1'b1, 1'($urandom), $urandom, 3, 1, 5, 0);
    chk("halt_halted", 64'(halted), 64'(1'b1));
    chk("halt_busy", 64'(busy), 64'(1'b0));
    chk("halt_pc", 64'(pc), 64'(pc_m));
    chk("halt_retired", 64'(retired), 64'(retired_m));
    repeat (12) begin
      drive(-1, 1'b0, 1);
      step();
      chk("halt_en", 64'(ens()), 64'(5'h00));
      chk("halt_stay", 64'(halted), 64'(1'b1));
      chk("halt_cycles", 64'(cycle_count), 64'(cyc_m));
    end

    // Reset during EXEC.
    do_reset();
    begin_run();
    run_instr(1'b0, 1'b0, 32'h0, 2, 1, 2, 0);
    step();
    chk_reset("post_midrst");

    // Watchdog on a stalled MEM stage.
    begin_run();
    run_instr(1'b0, 1'b0, 32'h0, 3, 1, 3, 1);
    repeat (6) begin
      drive(-1, 1'b0, 1);
      step();
      chk("err_stay", 64'(error), 64'(1'b1));
      chk("err_en", 64'(ens()), 64'(5'h00));
      chk("err_pc", 64'(pc), 64'(pc_m));
      chk("err_cycles", 64'(cycle_count), 64'(cyc_m));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
